carfield_periph_apb_bridge: RTL and testbench

CARFIELD_PERIPH_APB_BRIDGE -- requirements
Module: carfield_periph_apb_bridge

---
 rtl/carfield_periph_apb_pkg.sv | 53 +++++
 rtl/carfield_periph_apb_decode.sv | 29 ++
 rtl/carfield_periph_apb_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_carfield_periph_apb_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carfield_periph_apb_pkg.sv
// Shared definitions for the Carfield peripheral APB bridge.
// carfield_cfg_pkg carries the SoC-level peripheral base addresses;
// carfield_periph_apb_pkg derives the bridge's address map, slave index
// enum and FSM state type from it.

package carfield_cfg_pkg;

  localparam logic [31:0] CanBase      = 32'h2000_1000;
  localparam logic [31:0] TimerBase    = 32'h2000_4000;
  localparam logic [31:0] AdvTimerBase = 32'h2000_5000;
  localparam logic [31:0] WdtBase      = 32'h2000_7000;
  localparam logic [31:0] HyperBase    = 32'h2000_8000;

endpackage

package carfield_periph_apb_pkg;

  // Number of peripherals in the address map and the size of each window.
  localparam int          NumPeriphs = 5;
  localparam logic [31:0] PeriphSize = 32'h0000_1000;

  // Slave index; the value is the bit position in psel_o.
  typedef enum logic [2:0] {
    IDX_CAN       = 3'd0,
    IDX_TIMER     = 3'd1,
    IDX_ADV_TIMER = 3'd2,
    IDX_WDT       = 3'd3,
    IDX_HYPERBUS  = 3'd4
  } periph_idx_e;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Base address of the peripheral at index i (0 for out-of-range indices).
  function automatic logic [31:0] periph_base(input int i);
    logic [31:0] base;
    case (i)
      0:       base = carfield_cfg_pkg::CanBase;
      1:       base = carfield_cfg_pkg::TimerBase;
      2:       base = carfield_cfg_pkg::AdvTimerBase;
      3:       base = carfield_cfg_pkg::WdtBase;
      4:       base = carfield_cfg_pkg::HyperBase;
      default: base = 32'h0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/carfield_periph_apb_decode.sv
// Combinational address decoder: maps a request address onto one of the
// peripheral windows [base, base + PeriphSize). Windows whose index is not
// below NumApbSlaves are treated as unmapped.

module carfield_periph_apb_decode
  import carfield_periph_apb_pkg::*;
#(
  parameter int NumApbSlaves = 5
) (
  input  logic [31:0] addr_i,
  output logic        hit_o,
  output periph_idx_e idx_o
);

  // Half-open window compare against every peripheral in the map.
  always_comb begin
    hit_o = 1'b0;
    idx_o = IDX_CAN;
    for (int i = 0; i < NumPeriphs; i++) begin
      if ((i < NumApbSlaves) &&
          (addr_i >= periph_base(i)) &&
          (addr_i <  (periph_base(i) + PeriphSize))) begin
        hit_o = 1'b1;
        idx_o = periph_idx_e'(3'(i));
      end
    end
  end

endmodule

// File: rtl/carfield_periph_apb_bridge.sv
// Request/response to APB bridge for the Carfield peripheral cluster.
//
// Handshakes (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high; the initiator holds valid and its
// payload stable until that edge and never withdraws valid early.
// req_ready_o is high only in IDLE, rsp_valid_o only in RESP.
//
// Optional feature: define CARFIELD_APB_TIMEOUT_EN to abort APB accesses
// that see no pready within TimeoutCycles ACCESS cycles (error response).
// Without it, ACCESS waits for pready indefinitely.

module carfield_periph_apb_bridge
  import carfield_periph_apb_pkg::*;
#(
  parameter int NumApbSlaves  = 5,
  parameter int TimeoutCycles = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  // Request channel
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [31:0]                 req_addr_i,
  input  logic                        req_write_i,
  input  logic [31:0]                 req_wdata_i,
  input  logic [3:0]                  req_wstrb_i,
  // Response channel
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [31:0]                 rsp_rdata_o,
  output logic                        rsp_error_o,
  // APB master
  output logic [31:0]                 paddr_o,
  output logic                        pwrite_o,
  output logic [31:0]                 pwdata_o,
  output logic [3:0]                  pstrb_o,
  output logic [2:0]                  pprot_o,
  output logic [NumApbSlaves-1:0]     psel_o,
  output logic                        penable_o,
  input  logic [NumApbSlaves*32-1:0]  prdata_i,
  input  logic [NumApbSlaves-1:0]     pready_i,
  input  logic [NumApbSlaves-1:0]     pslverr_i,
  // Debug
  output apb_state_e                  dbg_state_o
);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 1");
  end

  apb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  periph_idx_e idx_q, idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;

  logic        dec_hit;
  periph_idx_e dec_idx;

  logic        pready_sel;
  logic        pslverr_sel;
  logic [31:0] prdata_sel;

`ifdef CARFIELD_APB_TIMEOUT_EN
  localparam int              CntW   = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  carfield_periph_apb_decode #(
    .NumApbSlaves (NumApbSlaves)
  ) u_decode (
    .addr_i (req_addr_i),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  // Pick the registered slave's response lines; all other slaves are ignored.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = 32'h0;
    for (int i = 0; i < NumApbSlaves; i++) begin
      if (int'(idx_q) == i) begin
        pready_sel  = pready_i[i];
        pslverr_sel = pslverr_i[i];
        prdata_sel  = prdata_i[i*32 +: 32];
      end
    end
  end

  // Next-state and datapath capture for the bridge FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    idx_d   = idx_q;
    rdata_d = rdata_q;
    error_d = error_q;
`ifdef CARFIELD_APB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = ST_SETUP;
          end else begin
            // Unmapped: answer with an error without touching the bus.
            rdata_d = 32'h0;
            error_d = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
`ifdef CARFIELD_APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_ACCESS: begin
        if (pready_sel) begin
          // pready takes priority over a timeout in the same cycle.
          rdata_d = write_q ? 32'h0 : prdata_sel;
          error_d = pslverr_sel;
          state_d = ST_RESP;
        end
`ifdef CARFIELD_APB_TIMEOUT_EN
        else if (cnt_q == CntMax) begin
          rdata_d = 32'h0;
          error_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= 32'h0;
      write_q <= 1'b0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'h0;
      idx_q   <= IDX_CAN;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

`ifdef CARFIELD_APB_TIMEOUT_EN
  // ACCESS-cycle counter for the timeout abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Decoded select: one-hot on the registered index during SETUP/ACCESS.
  always_comb begin
    psel_o = '0;
    for (int i = 0; i < NumApbSlaves; i++) begin
      psel_o[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) &&
                  (int'(idx_q) == i);
    end
  end

  assign penable_o   = (state_q == ST_ACCESS);
  assign paddr_o     = addr_q;
  assign pwrite_o    = write_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = wstrb_q;
  assign pprot_o     = 3'b000;
  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_carfield_periph_apb_bridge.sv
// Directed testbench for carfield_periph_apb_bridge. Expected responses are
// queued by the driver and popped by a separate response monitor.
// Build with CARFIELD_APB_TIMEOUT_EN to run the timeout scenario
// (TimeoutCycles = 8); the default build checks the indefinite wait.

module tb_carfield_periph_apb_bridge;
  import carfield_periph_apb_pkg::*;

  localparam int NS = 5;
`ifdef CARFIELD_APB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic              clk;
  logic              rst_n;
  logic              req_valid_i, req_ready_o, req_write_i;
  logic [31:0]       req_addr_i, req_wdata_i;
  logic [3:0]        req_wstrb_i;
  logic              rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [31:0]       rsp_rdata_o;
  logic [31:0]       paddr_o, pwdata_o;
  logic              pwrite_o, penable_o;
  logic [3:0]        pstrb_o;
  logic [2:0]        pprot_o;
  logic [NS-1:0]     psel_o, pready_i, pslverr_i;
  logic [NS*32-1:0]  prdata_i;
  apb_state_e        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  // Slave model configuration: wait cycles (-1: never ready), data, error.
  int          slv_wait = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic        slv_err = 1'b0;
  int          acc_cnt = 0;

  carfield_periph_apb_bridge #(
    .NumApbSlaves  (NS),
    .TimeoutCycles (TO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .paddr_o     (paddr_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .pprot_o     (pprot_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // APB slave model: non-selected slaves always shout pready/pslverr with
  // junk data, so the bridge must ignore them.
  always @(negedge clk) begin
    pready_i  = '1;
    pslverr_i = '1;
    for (int i = 0; i < NS; i++) prdata_i[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
    for (int i = 0; i < NS; i++) begin
      if (psel_o[i]) begin
        pready_i[i]  = 1'b0;
        pslverr_i[i] = 1'b0;
        prdata_i[i*32 +: 32] = 32'h0;
        if (penable_o && slv_wait >= 0 && acc_cnt == slv_wait) begin
          pready_i[i]  = 1'b1;
          pslverr_i[i] = slv_err;
          prdata_i[i*32 +: 32] = slv_rdata;
        end
      end
    end
    if (penable_o && psel_o != '0) acc_cnt++;
    else acc_cnt = 0;
  end

  // Response monitor / scoreboard plus select one-hot check.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_err_rdata", 64'({rsp_error_o, rsp_rdata_o}), 64'(e));
      end
    end
    if (rst_n && ($countones(psel_o) > 1))
      check("psel_onehot", 64'(psel_o), 64'd0);
  end

  // Driver: issue one request, track the APB phase, release the response.
  task automatic run_req(input string name, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int wait_c, input logic [31:0] s_rdata, input logic s_err,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input int exp_cyc, input logic [NS-1:0] exp_psel,
                         input int exp_psel_cyc, input int hold);
    int cyc;
    int psel_cyc;
    logic bad;
    logic [31:0] hold_rdata;
    logic hold_err;
    slv_wait  = wait_c;
    slv_rdata = s_rdata;
    slv_err   = s_err;
    @(negedge clk);
    check({name, "_req_ready"}, 64'(req_ready_o), 64'd1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wdata;
    req_wstrb_i = strb;
    exp_q.push_back({exp_err, exp_rdata});
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    cyc = 2;
    psel_cyc = 0;
    bad = 1'b0;
    while (1) begin
      @(negedge clk);
      if (psel_o != '0) begin
        psel_cyc++;
        if (psel_o !== exp_psel || paddr_o !== addr || pwrite_o !== wr ||
            pwdata_o !== wdata || pstrb_o !== strb || pprot_o !== 3'b000) bad = 1'b1;
      end
      if (rsp_valid_o) break;
      if (cyc > 2000) begin
        check({name, "_rsp_timeout"}, 64'(rsp_valid_o), 64'd1);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({name, "_psel_cycles"}, 64'(psel_cyc), 64'(exp_psel_cyc));
    check({name, "_apb_signals"}, 64'(bad), 64'd0);
    check({name, "_req_ready_busy"}, 64'(req_ready_o), 64'd0);
    hold_rdata = rsp_rdata_o;
    hold_err   = rsp_error_o;
    bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid_o || rsp_rdata_o !== hold_rdata || rsp_error_o !== hold_err ||
          req_ready_o !== 1'b0) bad = 1'b1;
    end
    if (hold > 0) check({name, "_hold_stable"}, 64'(bad), 64'd0);
    @(posedge clk);
    #1 rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    check({name, "_back_idle"}, 64'(req_ready_o), 64'd1);
  endtask

  // Request to a never-ready slave, then reset in the middle of ACCESS.
  task automatic stuck_then_reset(input int wait_cyc);
    int seen;
    slv_wait = -1;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h2000_4010;
    req_write_i = 1'b0;
    req_wdata_i = 32'h0;
    req_wstrb_i = 4'h0;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    seen = 0;
    for (int c = 0; c < wait_cyc; c++) begin
      @(negedge clk);
      if (rsp_valid_o) seen++;
    end
    check("stuck_no_rsp", 64'(seen), 64'd0);
    check("stuck_in_access", 64'({psel_o, penable_o}), 64'({5'b00010, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_psel", 64'(psel_o), 64'd0);
    check("async_rst_penable", 64'(penable_o), 64'd0);
    check("async_rst_paddr", 64'(paddr_o), 64'd0);
    check("async_rst_rsp", 64'({rsp_valid_o, rsp_error_o, rsp_rdata_o}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    slv_wait = 0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = 32'h0;
    req_write_i = 1'b0;
    req_wdata_i = 32'h0;
    req_wstrb_i = 4'h0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_apb", 64'({psel_o, penable_o, pwrite_o, pstrb_o, pprot_o}), 64'd0);
    check("rst_paddr_pwdata", 64'({paddr_o, pwdata_o}), 64'd0);
    check("rst_rsp", 64'({rsp_valid_o, rsp_error_o, rsp_rdata_o}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_ready", 64'(req_ready_o), 64'd1);

    // name addr wr wdata strb wait s_rdata s_err exp_err exp_rdata cyc psel pselcyc hold
    run_req("wr_can", 32'h2000_1004, 1'b1, 32'hA5A5_0001, 4'hF, 0, 32'hDEAD_BEEF, 1'b0,
            1'b0, 32'h0, 4, 5'b00001, 2, 0);
    run_req("rd_wdt", 32'h2000_7010, 1'b0, 32'h0, 4'h0, 3, 32'h1234_5678, 1'b0,
            1'b0, 32'h1234_5678, 7, 5'b01000, 5, 0);
    run_req("rd_unmapped", 32'h2000_2000, 1'b0, 32'h0, 4'h0, 0, 32'h5555_5555, 1'b0,
            1'b1, 32'h0, 2, 5'b00000, 0, 0);
    run_req("rd_hyper_err", 32'h2000_8000, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_0000, 1'b1,
            1'b1, 32'hCAFE_0000, 4, 5'b10000, 2, 5);
    run_req("rd_can_top", 32'h2000_1FFF, 1'b0, 32'h0, 4'h0, 0, 32'h1111_2222, 1'b0,
            1'b0, 32'h1111_2222, 4, 5'b00001, 2, 0);
    run_req("rd_below_can", 32'h2000_0FFF, 1'b0, 32'h0, 4'h0, 0, 32'h1, 1'b0,
            1'b1, 32'h0, 2, 5'b00000, 0, 0);
    run_req("rd_hyper_top", 32'h2000_8FFF, 1'b0, 32'h0, 4'h0, 1, 32'h0F0F_0F0F, 1'b0,
            1'b0, 32'h0F0F_0F0F, 5, 5'b10000, 3, 0);
    run_req("rd_above_hyper", 32'h2000_9000, 1'b0, 32'h0, 4'h0, 0, 32'h1, 1'b0,
            1'b1, 32'h0, 2, 5'b00000, 0, 0);
    run_req("rd_gap", 32'h2000_6000, 1'b0, 32'h0, 4'h0, 0, 32'h1, 1'b0,
            1'b1, 32'h0, 2, 5'b00000, 0, 0);
    run_req("wr_timer_err", 32'h2000_4FFC, 1'b1, 32'h0000_BEEF, 4'h3, 2, 32'h7777_7777, 1'b1,
            1'b1, 32'h0, 6, 5'b00010, 4, 0);
    run_req("rd_adv_timer", 32'h2000_5000, 1'b0, 32'h0, 4'h0, 0, 32'h8000_0001, 1'b0,
            1'b0, 32'h8000_0001, 4, 5'b00100, 2, 0);

`ifdef CARFIELD_APB_TIMEOUT_EN
    // 8 ACCESS cycles (cycles 3..10) then the error response in cycle 11.
    run_req("timeout", 32'h2000_7000, 1'b0, 32'h0, 4'h0, -1, 32'h9999_9999, 1'b0,
            1'b1, 32'h0, 11, 5'b01000, 9, 0);
    stuck_then_reset(4);
`else
    stuck_then_reset(1000);
`endif

    run_req("after_rst", 32'h2000_7004, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D, 1'b0,
            1'b0, 32'h0BAD_F00D, 4, 5'b01000, 2, 0);

    repeat (2) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "time limit");
  end

endmodule
